// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imm_gen_pipe                                                  |
// | Purpose  : Registered LEGv8 immediate generator (B/CB/I/D plus           |
// |            MOVZ/MOVK/MOVN wide immediates) with valid/ready handshake.   |
// |            Define IMMGEN_SKID_EN for a 2-entry skid FIFO on the output.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imm_gen_pipe #(
    parameter int DATA_W  = 64,
    parameter int SHIFT_B = 1
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25:0]       Imm26,
    input  logic [2:0]        Ctrl,
    input  logic              acc_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] BusImm,
    output logic              out_err
);

    localparam logic [2:0]  c_CTRL_B    = 3'b000;
    localparam logic [2:0]  c_CTRL_CB   = 3'b001;
    localparam logic [2:0]  c_CTRL_I    = 3'b010;
    localparam logic [2:0]  c_CTRL_D    = 3'b011;
    localparam logic [2:0]  c_CTRL_MOVZ = 3'b100;
    localparam logic [2:0]  c_CTRL_MOVK = 3'b101;
    localparam logic [2:0]  c_CTRL_MOVN = 3'b110;
    localparam logic [31:0] c_NSLICE    = 32'(DATA_W / 16);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_eff;
    logic [DATA_W-1:0] w_b_ext;
    logic [DATA_W-1:0] w_b_imm;
    logic [DATA_W-1:0] w_cb_ext;
    logic [DATA_W-1:0] w_cb_imm;
    logic [DATA_W-1:0] w_i_imm;
    logic [DATA_W-1:0] w_d_imm;
    logic [DATA_W-1:0] w_imm16_ext;
    logic [DATA_W-1:0] w_movz;
    logic [DATA_W-1:0] w_slice_mask;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W:0]   w_new;
    logic [15:0]       w_imm16;
    logic [1:0]        w_hw;
    logic [5:0]        w_shamt;
    logic              w_hw_ok;
    logic              w_err;
    logic              w_wide;
    logic              w_accept;
    logic              w_acc_load;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_bus;
    logic              r_out_err;

    assign w_accept = in_valid & in_ready;

    // Field extraction and extension for the branch/load/ALU formats
    assign w_b_ext  = {{(DATA_W-26){Imm26[25]}}, Imm26};
    assign w_cb_ext = {{(DATA_W-19){Imm26[23]}}, Imm26[23:5]};
    assign w_i_imm  = {{(DATA_W-12){1'b0}}, Imm26[21:10]};
    assign w_d_imm  = {{(DATA_W-9){Imm26[20]}}, Imm26[20:12]};

    generate
        if (SHIFT_B != 0) begin : g_shift_b
            assign w_b_imm  = w_b_ext << 2;
            assign w_cb_imm = w_cb_ext << 2;
        end else begin : g_no_shift_b
            assign w_b_imm  = w_b_ext;
            assign w_cb_imm = w_cb_ext;
        end
    endgenerate

    // Wide-immediate slice placement; hw beyond the bus width is an error
    assign w_imm16      = Imm26[20:5];
    assign w_hw         = Imm26[22:21];
    assign w_shamt      = {w_hw, 4'b0000};
    assign w_hw_ok      = ({30'd0, w_hw} < c_NSLICE);
    assign w_imm16_ext  = {{(DATA_W-16){1'b0}}, w_imm16};
    assign w_movz       = w_imm16_ext << w_shamt;
    assign w_slice_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << w_shamt;

    // A same-cycle clear is seen by the MOVK merge before the merge happens
    assign w_acc_eff = acc_clear ? '0 : r_acc;

    always_comb begin
        w_res  = '0;
        w_err  = 1'b0;
        w_wide = 1'b0;
        case (Ctrl)
            c_CTRL_B:  w_res = w_b_imm;
            c_CTRL_CB: w_res = w_cb_imm;
            c_CTRL_I:  w_res = w_i_imm;
            c_CTRL_D:  w_res = w_d_imm;
            c_CTRL_MOVZ: begin
                w_wide = 1'b1;
                if (w_hw_ok) w_res = w_movz;
                else         w_err = 1'b1;
            end
            c_CTRL_MOVK: begin
                w_wide = 1'b1;
                if (w_hw_ok) w_res = (w_acc_eff & ~w_slice_mask) | w_movz;
                else         w_err = 1'b1;
            end
            c_CTRL_MOVN: begin
                w_wide = 1'b1;
                if (w_hw_ok) w_res = ~w_movz;
                else         w_err = 1'b1;
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_new      = {w_err, w_res};
    assign w_acc_load = w_accept & w_wide & ~w_err;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_acc <= '0;
        end else if (w_acc_load) begin
            r_acc <= w_res;
        end else if (acc_clear) begin
            r_acc <= '0;
        end
    end

`ifdef IMMGEN_SKID_EN
    logic [DATA_W:0] r_q0;
    logic [DATA_W:0] r_q1;
    logic [1:0]      r_cnt;
    logic            w_out_free;
    logic            w_take;
    logic            w_direct;
    logic            w_push;

    // in_ready depends on the FIFO count register only
    assign in_ready   = ~r_cnt[1];
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_take     = w_out_free & (r_cnt != 2'd0);
    assign w_direct   = w_accept & w_out_free & (r_cnt == 2'd0);
    assign w_push     = w_accept & ~w_direct;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_out_valid <= 1'b0;
            r_out_bus   <= '0;
            r_out_err   <= 1'b0;
            r_q0        <= '0;
            r_q1        <= '0;
            r_cnt       <= 2'd0;
        end else begin
            if (w_take) begin
                r_out_valid            <= 1'b1;
                {r_out_err, r_out_bus} <= r_q0;
            end else if (w_direct) begin
                r_out_valid <= 1'b1;
                r_out_err   <= w_err;
                r_out_bus   <= w_res;
            end else if (w_out_free) begin
                r_out_valid <= 1'b0;
            end

            if (w_take && w_push) begin
                if (r_cnt == 2'd1) begin
                    r_q0 <= w_new;
                end else begin
                    r_q0 <= r_q1;
                    r_q1 <= w_new;
                end
            end else if (w_take) begin
                r_q0  <= r_q1;
                r_cnt <= r_cnt - 2'd1;
            end else if (w_push) begin
                if (r_cnt == 2'd0) r_q0 <= w_new;
                else               r_q1 <= w_new;
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end
`else
    assign in_ready = ~r_out_valid | out_ready;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_out_valid <= 1'b0;
            r_out_bus   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_bus   <= w_res;
            r_out_err   <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign BusImm    = r_out_bus;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire
